// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: frame sequencer between the SPI slave byte port and a register file.
// Each frame is a command byte (bit7 write, low bits address) followed by a data burst.
module spi_reg_ctrl #(
  parameter int         ADDR_W    = 4,
  parameter int         MAX_BURST = 16,
  parameter logic [7:0] IDLE_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ss_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_byte,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_load,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_busy,
  output logic              o_burst_err,
  output logic [7:0]        o_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_rst_q;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [7:0]        r_bcnt;

  logic              w_full;
  logic              w_cmd;
  logic              w_wr;
  logic              w_rd;
  logic              w_load;
  logic              w_end;
  logic              w_cnt;
  logic              w_err;
  logic [ADDR_W-1:0] w_cmd_addr;

  assign w_cmd_addr = i_rx_byte[ADDR_W-1:0];
  assign w_full     = (r_bcnt == 8'(MAX_BURST));
  assign o_busy     = (r_state != S_IDLE);

  // Read address is driven in the rx_valid cycle so data returns in time
  // for a fixed two-cycle tx_load.
  assign o_rd_addr = w_rd ? (w_cmd ? w_cmd_addr : r_ptr) : r_rd_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_cmd  = 1'b0;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    w_load = 1'b0;
    w_end  = 1'b0;
    w_cnt  = 1'b0;
    w_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!i_ss_n) begin
          w_next = r_rst_q ? S_DRAIN : S_CMD;
          w_err  = r_rst_q;
        end
      end
      S_CMD: begin
        if (i_rx_valid) begin
          w_cmd  = 1'b1;
          w_rd   = ~i_rx_byte[7];
          w_next = i_rx_byte[7] ? S_WRITE : S_READ;
        end else if (i_ss_n) begin
          w_end  = 1'b1;
          w_cnt  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WRITE, S_READ: begin
        if (i_rx_valid) begin
          if (w_full) begin
            w_err  = 1'b1;
            w_next = S_DRAIN;
          end else if (r_state == S_WRITE) begin
            w_wr = 1'b1;
          end else begin
            w_rd = 1'b1;
          end
        end else if (i_ss_n) begin
          w_end  = 1'b1;
          w_cnt  = 1'b1;
          w_next = S_IDLE;
        end
        if (r_state == S_READ)
          w_load = r_rd_pend && !w_end && !w_err;
      end
      S_DRAIN: begin
        if (i_ss_n) begin
          w_end  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_q     <= 1'b1;
      r_rd_pend   <= 1'b0;
      r_ptr       <= '0;
      r_rd_addr   <= '0;
      r_bcnt      <= '0;
      o_tx_byte   <= IDLE_BYTE;
      o_tx_load   <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_burst_err <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      r_rst_q   <= 1'b0;
      r_rd_pend <= w_rd;
      o_wr_en   <= w_wr;
      o_tx_load <= w_load | w_end;
      if (w_rd)
        r_rd_addr <= o_rd_addr;
      if (w_cmd) begin
        r_ptr       <= w_cmd_addr;
        r_bcnt      <= '0;
        o_burst_err <= 1'b0;
      end
      if ((w_rd && !w_cmd) || w_wr)
        r_bcnt <= r_bcnt + 8'd1;
      if (w_wr) begin
        o_wr_addr <= r_ptr;
        o_wr_data <= i_rx_byte;
        r_ptr     <= r_ptr + 1'b1;
      end
      if (w_load) begin
        o_tx_byte <= i_rd_data;
        r_ptr     <= r_ptr + 1'b1;
      end
      if (w_end)
        o_tx_byte <= IDLE_BYTE;
      if (w_err)
        o_burst_err <= 1'b1;
      if (w_cnt)
        o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed and random SPI frames checked against a
// frame-level model; a small register array stands in for the regfile.
module tb_spi_reg_ctrl;
  localparam int         AW = 4;
  localparam int         MB = 3;
  localparam logic [7:0] IB = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ss_n = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [7:0]    tx_byte;
  logic          tx_load;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          burst_err;
  logic [7:0]    frame_cnt;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(AW), .MAX_BURST(MB), .IDLE_BYTE(IB)) dut (
    .clk(clk), .rst(rst), .i_ss_n(ss_n),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_tx_byte(tx_byte), .o_tx_load(tx_load),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_busy(busy), .o_burst_err(burst_err), .o_frame_cnt(frame_cnt)
  );

  logic [7:0] mem [16];
  logic       pre_we = 1'b0;
  logic [3:0] pre_a = 4'h0;
  logic [7:0] pre_d = 8'h00;

  always @(posedge clk) begin
    if (pre_we)     mem[pre_a] <= pre_d;
    else if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed and expected events: {addr,data,cycle} and {byte,cycle}.
  logic [43:0] wq[$], ew[$];
  logic [39:0] tq[$], et[$];

  always @(negedge clk) begin
    if (wr_en)   wq.push_back({wr_addr, wr_data, 32'(cyc)});
    if (tx_load) tq.push_back({tx_byte, 32'(cyc)});
  end

  int total = 0;
  int bad = 0;

  logic [7:0] ref_mem [16];
  bit         m_have_cmd, m_is_wr, m_drain;
  int         m_base, m_n;
  logic [7:0] e_cnt = 8'd0;
  logic       e_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string t);
    chk({t, " tx_byte"}, tx_byte, IB);
    chk({t, " tx_load"}, tx_load, 0);
    chk({t, " wr_en"}, wr_en, 0);
    chk({t, " wr_addr"}, wr_addr, 0);
    chk({t, " wr_data"}, wr_data, 0);
    chk({t, " rd_addr"}, rd_addr, 0);
    chk({t, " busy"}, busy, 0);
    chk({t, " err"}, burst_err, 0);
    chk({t, " cnt"}, frame_cnt, 0);
  endtask

  task automatic end_model(input int pc);
    et.push_back({IB, 32'(pc)});
    if (!m_drain) e_cnt++;
  endtask

  // Frame rules: cmd sets base; data byte k (1-based) targets base+k-1
  // for writes, and a read frame returns mem[base], mem[base+1], ...
  task automatic model_byte(input logic [7:0] b, input int c, input bit rise);
    logic [3:0] a;
    if (m_drain) return;
    if (!m_have_cmd) begin
      m_have_cmd = 1; m_is_wr = b[7]; m_base = int'(b[3:0]);
      m_n = 0; e_err = 0;
      if (!b[7] && !rise) et.push_back({ref_mem[m_base], 32'(c + 2)});
    end else if (m_n == MB) begin
      m_drain = 1; e_err = 1;
    end else begin
      m_n++;
      if (m_is_wr) begin
        a = 4'((m_base + m_n - 1) % 16);
        ew.push_back({a, b, 32'(c + 1)});
        ref_mem[a] = b;
      end else if (!rise) begin
        a = 4'((m_base + m_n) % 16);
        et.push_back({ref_mem[a], 32'(c + 2)});
      end
    end
  endtask

  task automatic f_start();
    wq.delete(); tq.delete(); ew.delete(); et.delete();
    m_have_cmd = 0; m_drain = 0; m_n = 0;
    @(negedge clk); ss_n = 1'b0;
    tick(3);
  endtask

  task automatic f_byte(input logic [7:0] b, input bit rise);
    int c;
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = b; c = cyc;
    if (rise) ss_n = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_byte = 8'($urandom);
    model_byte(b, c, rise);
    if (rise) end_model(c + 2);
    tick(6);
  endtask

  task automatic f_stop();
    int s;
    @(negedge clk); ss_n = 1'b1; s = cyc;
    end_model(s + 1);
    tick(4);
  endtask

  task automatic check_frame(input string t);
    chk({t, " nwr"}, wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++)
      chk({t, " wr"}, wq[i], ew[i]);
    chk({t, " ntx"}, tq.size(), et.size());
    for (int i = 0; i < et.size() && i < tq.size(); i++)
      chk({t, " tx"}, tq[i], et[i]);
    chk({t, " cnt"}, frame_cnt, e_cnt);
    chk({t, " err"}, burst_err, e_err);
    chk({t, " busy"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_a = 4'(i); pre_d = 8'($urandom);
      ref_mem[i] = pre_d;
    end
    @(negedge clk); pre_we = 1'b0;
    chk_reset("rst0");
    @(negedge clk); rst = 1'b0;
    tick(3);
    chk("idle busy", busy, 0);

    f_start();
    f_byte(8'h82, 0); f_byte(8'h11, 0); f_byte(8'h22, 0); f_byte(8'h33, 0);
    f_stop();
    check_frame("write");

    f_start();
    f_byte(8'h85, 0); f_byte(8'h5A, 0); f_byte(8'hC3, 0);
    f_stop();
    check_frame("preload");

    f_start();
    f_byte(8'h05, 0); f_byte(8'h00, 0); f_byte(8'hFF, 0);
    chk("read busy", busy, 1);
    f_stop();
    check_frame("read");
    if (tq.size() > 1) begin
      chk("read first", tq[0][39:32], 8'h5A);
      chk("read second", tq[1][39:32], 8'hC3);
    end

    f_start();
    f_byte(8'h8F, 0); f_byte(8'h6E, 0); f_byte(8'h91, 0);
    f_stop();
    check_frame("wrap wr");
    f_start();
    f_byte(8'h0F, 0); f_byte(8'h00, 0);
    f_stop();
    check_frame("wrap rd");

    f_start();
    f_byte(8'h80, 0);
    for (int i = 0; i < MB + 1; i++) f_byte(8'(8'h40 + i), 0);
    chk("burst drain busy", busy, 1);
    f_stop();
    check_frame("burst");
    f_start();
    f_byte(8'h01, 0);
    chk("err cleared", burst_err, 0);
    f_byte(8'h00, 0);
    f_stop();
    check_frame("after burst");

    f_start();
    f_stop();
    check_frame("empty");

    f_start();
    f_byte(8'h84, 0); f_byte(8'hAA, 0); f_byte(8'hBB, 1);
    check_frame("edge rise");
    chk("edge tx_byte", tx_byte, IB);

    wq.delete(); tq.delete();
    @(negedge clk); rx_valid = 1'b1; rx_byte = 8'h9C;
    @(negedge clk); rx_valid = 1'b0;
    tick(4);
    chk("idle rx nwr", wq.size(), 0);
    chk("idle rx ntx", tq.size(), 0);
    chk("idle rx busy", busy, 0);

    f_start();
    f_byte(8'h83, 0); f_byte(8'h44, 0);
    @(negedge clk); rst = 1'b1;
    tick(3);
    chk_reset("rstmid");
    e_cnt = 8'd0;
    @(negedge clk); rst = 1'b0;
    m_drain = 1; e_err = 1;
    tick(3);
    chk("drain busy", busy, 1);
    chk("drain err", burst_err, 1);
    f_byte(8'h66, 0); f_byte(8'h77, 0);
    f_stop();
    check_frame("rst drain");
    f_start();
    f_byte(8'h8A, 0); f_byte(8'h12, 0);
    f_stop();
    check_frame("post rst");

    for (int k = 0; k < 40; k++) begin
      int n;
      bit rise;
      logic [7:0] cmd;
      f_start();
      if ($urandom_range(0, 9) == 0) begin
        f_stop();
      end else begin
        cmd = 8'($urandom);
        n = $urandom_range(0, MB + 1);
        rise = ($urandom_range(0, 3) == 0);
        f_byte(cmd, rise && n == 0);
        for (int j = 0; j < n; j++)
          f_byte(8'($urandom), rise && j == n - 1);
        if (!rise) f_stop();
      end
      check_frame("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
